// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
//   Sequences a serial 0110 Moore detector over a parallel word. A start
//   captures data_in, pulses the detector reset for one cycle and shifts the
//   word out MSB-first. The detector output for each bit is sampled one cycle
//   after that bit is presented. The block reports the hit count, the first
//   hit position and a found flag, then pulses done.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   start        scan request, accepted in IDLE or DONE
//   abort        cancel an in-progress scan (priority over start)
//   data_in      word to scan, captured on the accepting edge
//   busy         high in CLEAR, SHIFT and DRAIN (registered)
//   done         one-cycle pulse, results valid
//   det_reset    detector reset (registered)
//   det_seq      detector serial input
//   det_hit      detector Moore output
//   match_count  saturating hit count of the last scan
//   first_pos    bit index of the first hit (0 = MSB)
//   found        at least one hit in the last scan
module seq_scan_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned POS_W = 4,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             det_reset,
  output logic             det_seq,
  input  logic             det_hit,
  output logic [CNT_W-1:0] match_count,
  output logic [POS_W-1:0] first_pos,
  output logic             found
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_shift;
  logic [POS_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_count;
  logic [POS_W-1:0]   r_first;
  logic               r_found;
  logic               r_busy;
  logic               r_det_reset;
  logic               r_rst_q;

  logic               w_accept;
  logic               w_abort;
  logic               w_sample;
  logic               w_last;
  logic [POS_W-1:0]   w_pos;
  logic               w_done;
  logic               w_det_seq;

  // Next-state and per-cycle control decode.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_abort   = 1'b0;
    w_sample  = 1'b0;
    w_pos     = '0;
    w_last    = (r_idx == POS_W'(WIDTH - 1));
    w_done    = 1'b0;
    w_det_seq = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (start && !abort) begin
          w_accept = 1'b1;
          w_next   = S_CLEAR;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_det_seq = r_shift[WIDTH-1];
        if (abort) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          // The detector output seen now belongs to the previous bit.
          w_sample = (r_idx != '0);
          w_pos    = r_idx - POS_W'(1);
          if (w_last) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_sample = 1'b1;
          w_pos    = POS_W'(WIDTH - 1);
          w_next   = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Detector reset is held one extra cycle after reset drops so the
  // detector leaves reset cleanly after the controller does.
  always_ff @(posedge clock) begin
    r_rst_q <= reset;
    if (reset) begin
      r_det_reset <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_det_reset <= r_rst_q | w_abort | (w_next == S_CLEAR);
      r_busy      <= (w_next == S_CLEAR) || (w_next == S_SHIFT) ||
                     (w_next == S_DRAIN);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_first <= '0;
      r_found <= 1'b0;
    end else if (w_accept) begin
      r_shift <= data_in;
      r_idx   <= '0;
      r_count <= '0;
      r_first <= '0;
      r_found <= 1'b0;
    end else if (w_abort) begin
      r_count <= '0;
      r_first <= '0;
      r_found <= 1'b0;
    end else begin
      if (r_state == S_SHIFT) begin
        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
        r_idx   <= r_idx + POS_W'(1);
      end
      if (w_sample && det_hit) begin
        if (r_count != '1) r_count <= r_count + CNT_W'(1);
        if (!r_found) begin
          r_found <= 1'b1;
          r_first <= w_pos;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign det_reset   = r_det_reset;
  assign done        = w_done;
  assign det_seq     = w_det_seq;
  assign match_count = r_count;
  assign first_pos   = r_first;
  assign found       = r_found;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] data_in;

  logic        busy1, done1, det_reset1, det_seq1, det_hit1, found1;
  logic [4:0]  count1;
  logic [3:0]  first1;
  logic        busy2, done2, det_reset2, det_seq2, det_hit2, found2;
  logic [1:0]  count2;
  logic [3:0]  first2;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  seq_scan_ctrl #(.WIDTH(16), .POS_W(4), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .data_in(data_in), .busy(busy1), .done(done1), .det_reset(det_reset1),
    .det_seq(det_seq1), .det_hit(det_hit1), .match_count(count1),
    .first_pos(first1), .found(found1)
  );

  seq_scan_ctrl #(.WIDTH(16), .POS_W(4), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .data_in(data_in), .busy(busy2), .done(done2), .det_reset(det_reset2),
    .det_seq(det_seq2), .det_hit(det_hit2), .match_count(count2),
    .first_pos(first2), .found(found2)
  );

  // Detector stand-ins: last four bits seen since reset equal 0110.
  logic [3:0] h1 = '0, h2 = '0;
  int         n1 = 0,  n2 = 0;
  always @(posedge clock) begin
    if (det_reset1) begin h1 <= '0; n1 <= 0; end
    else begin h1 <= {h1[2:0], det_seq1}; if (n1 < 8) n1 <= n1 + 1; end
    if (det_reset2) begin h2 <= '0; n2 <= 0; end
    else begin h2 <= {h2[2:0], det_seq2}; if (n2 < 8) n2 <= n2 + 1; end
  end
  assign det_hit1 = (n1 >= 4) && (h1 == 4'b0110);
  assign det_hit2 = (n2 >= 4) && (h2 == 4'b0110);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scan result straight from the word: count 0110 windows MSB-first.
  task automatic ref_scan(input logic [15:0] w, input int cmax,
                          output int cnt, output int fp, output int fnd);
    cnt = 0; fp = 0; fnd = 0;
    for (int i = 3; i < 16; i++) begin
      logic [15:0] sh;
      sh = w >> (15 - i);
      if (sh[3:0] == 4'b0110) begin
        if (fnd == 0) begin fnd = 1; fp = i; end
        if (cnt < cmax) cnt++;
      end
    end
  endtask

  int e_cnt1, e_pos1, e_fnd1, e_cnt2, e_pos2, e_fnd2;

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic scan(input logic [15:0] w);
    int cyc;
    bit dr_ok, busy_ok, seq_ok;
    logic exp_seq;
    ref_scan(w, 31, e_cnt1, e_pos1, e_fnd1);
    ref_scan(w, 3,  e_cnt2, e_pos2, e_fnd2);
    start = 1'b1; data_in = w;
    @(negedge clock);
    start = 1'b0; data_in = 16'($urandom);
    chk("clr_count", count1, 0);
    chk("clr_found", found1, 0);
    chk("clr_first", first1, 0);
    cyc = 1; dr_ok = 1; busy_ok = 1; seq_ok = 1;
    while (done1 !== 1'b1 && cyc < 40) begin
      if (det_reset1 !== (cyc == 1)) dr_ok = 0;
      if (busy1 !== 1'b1) busy_ok = 0;
      exp_seq = (cyc >= 2 && cyc <= 17) ? w[17 - cyc] : 1'b0;
      if (det_seq1 !== exp_seq) seq_ok = 0;
      @(negedge clock);
      cyc++;
    end
    chk("latency", cyc, 19);
    chk("det_reset_window", dr_ok, 1);
    chk("busy_window", busy_ok, 1);
    chk("det_seq_stream", seq_ok, 1);
    chk("busy_in_done", busy1, 0);
    chk("count", count1, e_cnt1);
    chk("first_pos", first1, e_pos1);
    chk("found", found1, e_fnd1);
    chk("sat_done", done2, 1);
    chk("sat_count", count2, e_cnt2);
    chk("sat_first", first2, e_pos2);
    chk("sat_found", found2, e_fnd2);
  endtask

  task automatic idle_chk();
    @(negedge clock);
    chk("idle_done", done1, 0);
    chk("idle_busy", busy1, 0);
    chk("idle_seq", det_seq1, 0);
    chk("hold_count", count1, e_cnt1);
    chk("hold_first", first1, e_pos1);
    chk("hold_found", found1, e_fnd1);
  endtask

  initial begin
    bit no_done;
    logic [15:0] w;
    logic [3:0]  nib;
    reset = 1'b1; start = 1'b0; abort = 1'b0; data_in = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_seq", det_seq1, 0);
    chk("rst_count", count1, 0);
    chk("rst_first", first1, 0);
    chk("rst_found", found1, 0);
    chk("rst_det_reset", det_reset1, 1);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_tail_det_reset", det_reset1, 1);
    @(negedge clock);
    chk("post_rst_det_reset", det_reset1, 0);

    scan(16'h6000); idle_chk();
    scan(16'h6C00); idle_chk();
    scan(16'h6666); idle_chk();
    scan(16'hFFFF);
    scan(16'h6000);   // start presented during DONE
    idle_chk();

    // abort in the middle of a scan
    start = 1'b1; data_in = 16'h6666;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    chk("pre_abort_count", count1, 1);
    chk("pre_abort_found", found1, 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_busy", busy1, 0);
    chk("abort_done", done1, 0);
    chk("abort_count", count1, 0);
    chk("abort_first", first1, 0);
    chk("abort_found", found1, 0);
    chk("abort_det_reset", det_reset1, 1);
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy1, 0);
    chk("start_abort_det_reset", det_reset1, 0);
    no_done = 1;
    repeat (25) begin
      @(negedge clock);
      if (done1 !== 1'b0 || busy1 !== 1'b0) no_done = 0;
    end
    chk("abort_no_done", no_done, 1);

    // reset during SHIFT
    start = 1'b1; data_in = 16'h6666;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    chk("pre_reset_busy", busy1, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_seq", det_seq1, 0);
    chk("mid_rst_count", count1, 0);
    chk("mid_rst_first", first1, 0);
    chk("mid_rst_found", found1, 0);
    chk("mid_rst_det_reset", det_reset1, 1);
    @(negedge clock);
    chk("mid_rst_tail", det_reset1, 1);
    @(negedge clock);
    scan(16'h6000); idle_chk();

    // randomized words, biased toward 0110 nibbles, random back-to-back
    for (int k = 0; k < 40; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        nib = ($urandom_range(0, 1) == 1) ? 4'h6 : 4'($urandom);
        w = {w[11:0], nib};
      end
      if ($urandom_range(0, 3) == 0) w = 16'($urandom);
      scan(w);
      if ($urandom_range(0, 1) == 1) idle_chk();
    end
    idle_chk();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Controller that sequences the serial 0110 Moore detector over a parallel word. On `start` it captures a WIDTH-bit word, clears the detector, shifts the word into it MSB-first one bit per clock, and samples the detector's Moore output one cycle after each bit. It reports the match count, the position of the first match and a found flag, then pulses `done`. It sits between the parallel data source and the detector instance, which it owns exclusively.

## Interface
Parameters:
- WIDTH, 16: bits per scanned word; minimum 4.
- POS_W, 4: width of `first_pos`; must satisfy 2^POS_W >= WIDTH.
- CNT_W, 5: width of `match_count`; the count saturates at 2^CNT_W-1.

Ports:
- clock  in  1  single clock; all flops rise-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a scan; accepted only in IDLE or DONE.
- abort  in  1  cancel an in-progress scan.
- data_in  in  WIDTH  word to scan; sampled on the accepting edge.
- busy  out  1  high in CLEAR, SHIFT and DRAIN.
- done  out  1  one-cycle pulse; results valid.
- det_reset  out  1  to the detector `reset`.
- det_seq  out  1  to the detector `seq_in`.
- det_hit  in  1  from the detector `seq_out` (Moore).
- match_count  out  CNT_W  number of hits in the last scan.
- first_pos  out  POS_W  bit index of the first hit (0 = MSB, the first bit shifted).
- found  out  1  at least one hit in the last scan.

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE: on start=1 and abort=0, do all of the following, then go to CLEAR:
  - load the shift register from `data_in`;
  - clear the bit index, `match_count`, `first_pos` and `found`.
- CLEAR: `det_reset`=1 for exactly this one cycle; go to SHIFT.
- SHIFT: `det_seq` = shift register MSB; shift left every cycle; the index counts 0..WIDTH-1.
  - When index = WIDTH-1, go to DRAIN.
  - In every SHIFT cycle except the first, sample `det_hit` as the result for bit index-1.
- DRAIN: `det_seq`=0. Sample `det_hit` for bit WIDTH-1. Go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE. A start in DONE is accepted exactly as in IDLE; `done` still pulses.
- Hit handling: on a sampled hit, `match_count` increments, saturating at 2^CNT_W-1. On the first hit of a scan, also set `found`=1 and `first_pos`=bit index. Later hits do not change `first_pos`.
- Overlapping matches count; the count is determined by the detector. For example, 0110110 yields 2 hits.
- `det_seq`=0 outside SHIFT. `det_hit` is ignored outside the sampling slots.
- abort=1 in CLEAR, SHIFT or DRAIN:
  - go to IDLE next cycle with no `done` pulse;
  - clear `match_count`, `first_pos` and `found` to 0;
  - assert `det_reset` in that next cycle.
- abort has priority over start in every state. abort in IDLE or DONE is otherwise a no-op.
- Results hold from DONE until the next accepted start.
- `det_reset` and `busy` come straight from flops; no combinational decode to the detector's asynchronous reset.

## Timing
- Start sampled at edge E0:
  - cycle 1: CLEAR;
  - cycles 2..WIDTH+1: bit i presented in cycle 2+i;
  - `det_hit` for bit i is valid in cycle 3+i and sampled at the end of that cycle;
  - cycle WIDTH+2: DRAIN;
  - cycle WIDTH+3: `done`=1.
- Start-to-done latency: WIDTH+3 cycles (19 for WIDTH=16).
- Back-to-back: a start in the DONE cycle gives CLEAR in the next cycle. Throughput is one word per WIDTH+3 cycles.
- reset=1 at any edge, including mid-scan:
  - state goes to IDLE;
  - `busy`, `done`, `det_seq`, `match_count`, `first_pos` and `found` all go to 0;
  - `det_reset`=1 for every cycle reset is high, plus one cycle after.

## Test plan
- WIDTH=16, data 0x6000 -> `done` 19 cycles after start, count=1, first_pos=3, found=1.
- data 0x6C00 (overlap) -> count=2, first_pos=3. Check `det_reset` high only in cycle 1.
- data 0x6666 -> count=4, first_pos=3. The last hit (bit 15) must be captured in DRAIN. Rerun with CNT_W=2 -> count=3 (saturated).
- data 0xFFFF -> count=0, found=0, first_pos=0. Then start asserted during DONE -> new scan begins the next cycle with results cleared.
- start 0x6666; abort at cycle 8 -> IDLE at cycle 9, no `done`, outputs 0, `det_reset`=1 in cycle 9. A start together with abort in IDLE is ignored.
- reset asserted mid-SHIFT -> all outputs 0 on the next edge, `det_reset` high. A following scan of 0x6000 gives count=1.
